// File: rtl/fp_normalize_round_if.sv
// Handshake and datapath bundle for the normalise-and-round stage.
// The master side drives operands and out_ready; the slave side is the stage itself.
interface fp_normalize_round_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic                   in_carry;
  logic [MAN_W:0]         in_man;
  logic [2:0]             in_grs;
  logic [1:0]             in_rm;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
  logic [3:0]             out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_carry, in_man, in_grs, in_rm, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_carry, in_man, in_grs, in_rm, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_normalize_round.sv
// Normalise-and-round stage for the FP adder: one right shift or left shifts, four rounding modes, flags.
// Define FPNR_FAST_NORM_EN to do the whole left normalisation in a single NORM cycle.
//
// state | meaning
// IDLE  | ready for an operand; right shift on adder carry happens at capture
// NORM  | left-shifting until the hidden bit is set or the exponent reaches 1
// ROUND | apply rounding increment, detect overflow, build result and flags
// DONE  | result held until out_ready
module fp_normalize_round #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic               clk,
  input logic               rst_n,
  fp_normalize_round_if.slave bus
);
  localparam int EW = EXP_W + 1;
  localparam int RW = EXP_W + MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t           state, state_nx;
  logic             sign_q, sign_nx;
  logic [EW-1:0]    exp_q, exp_nx;
  logic [MAN_W:0]   man_q, man_nx;
  logic             g_q, g_nx, r_q, r_nx, s_q, s_nx;
  logic [1:0]       rm_q, rm_nx;
  logic             ez_q, ez_nx;
  logic [RW-1:0]    res_q, res_nx;
  logic [3:0]       flg_q, flg_nx;

  logic             inc, inexact, sub, ovf, to_inf;
  logic [MAN_W+1:0] sum;
  logic [EW-1:0]    e_rnd;
  logic [MAN_W-1:0] frac;
`ifdef FPNR_FAST_NORM_EN
  logic [MAN_W+2:0] nv;
  int               lz, shamt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      exp_q  <= '0;
      man_q  <= '0;
      g_q    <= 1'b0;
      r_q    <= 1'b0;
      s_q    <= 1'b0;
      rm_q   <= '0;
      ez_q   <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      state  <= state_nx;
      sign_q <= sign_nx;
      exp_q  <= exp_nx;
      man_q  <= man_nx;
      g_q    <= g_nx;
      r_q    <= r_nx;
      s_q    <= s_nx;
      rm_q   <= rm_nx;
      ez_q   <= ez_nx;
      res_q  <= res_nx;
      flg_q  <= flg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sign_nx  = sign_q;
    exp_nx   = exp_q;
    man_nx   = man_q;
    g_nx     = g_q;
    r_nx     = r_q;
    s_nx     = s_q;
    rm_nx    = rm_q;
    ez_nx    = ez_q;
    res_nx   = res_q;
    flg_nx   = flg_q;
    inc      = 1'b0;
    inexact  = 1'b0;
    sub      = 1'b0;
    ovf      = 1'b0;
    to_inf   = 1'b0;
    sum      = '0;
    e_rnd    = '0;
    frac     = '0;
`ifdef FPNR_FAST_NORM_EN
    nv       = '0;
    lz       = 0;
    shamt    = 0;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sign_nx = bus.in_sign;
          rm_nx   = bus.in_rm;
          ez_nx   = (bus.in_exp == '0);
          if (bus.in_carry) begin
            man_nx   = {1'b1, bus.in_man[MAN_W:1]};
            g_nx     = bus.in_man[0];
            r_nx     = bus.in_grs[2];
            s_nx     = bus.in_grs[1] | bus.in_grs[0];
            exp_nx   = {1'b0, bus.in_exp} + EW'(1);
            state_nx = ROUND;
          end else begin
            man_nx             = bus.in_man;
            {g_nx, r_nx, s_nx} = bus.in_grs;
            exp_nx             = {1'b0, bus.in_exp};
            if (bus.in_man == '0 && bus.in_grs == '0)
              state_nx = ROUND;
            else if (!bus.in_man[MAN_W] && bus.in_exp > EXP_W'(1))
              state_nx = NORM;
            else
              state_nx = ROUND;
          end
        end
      end
`ifdef FPNR_FAST_NORM_EN
      NORM: begin
        // guard and round shift in behind the fraction; sticky stays put
        nv = {man_q, g_q, r_q};
        lz = MAN_W + 3;
        for (int i = 0; i < MAN_W + 3; i++)
          if (nv[i]) lz = MAN_W + 2 - i;
        shamt = (lz > int'(exp_q) - 1) ? int'(exp_q) - 1 : lz;
        nv = nv << shamt;
        {man_nx, g_nx, r_nx} = nv;
        exp_nx   = exp_q - EW'(shamt);
        state_nx = ROUND;
      end
`else
      NORM: begin
        man_nx = {man_q[MAN_W-1:0], g_q};
        g_nx   = r_q;
        r_nx   = 1'b0;
        exp_nx = exp_q - EW'(1);
        if (man_nx[MAN_W] || exp_nx == EW'(1))
          state_nx = ROUND;
      end
`endif
      ROUND: begin
        inexact = g_q | r_q | s_q;
        case (rm_q)
          2'b00:   inc = g_q & (r_q | s_q | man_q[0]);
          2'b01:   inc = 1'b0;
          2'b10:   inc = !sign_q & inexact;
          default: inc = sign_q & inexact;
        endcase
        sum = {1'b0, man_q} + {{(MAN_W+1){1'b0}}, inc};
        sub = !man_q[MAN_W] || ez_q;
        if (sum[MAN_W+1]) begin
          e_rnd = exp_q + EW'(1);
          frac  = '0;
        end else if (sub) begin
          // a subnormal that rounds into the hidden bit becomes the smallest normal
          e_rnd = sum[MAN_W] ? EW'(1) : EW'(0);
          frac  = sum[MAN_W-1:0];
        end else begin
          e_rnd = exp_q;
          frac  = sum[MAN_W-1:0];
        end
        ovf = (e_rnd >= {1'b0, EXP_ONES});
        if (ovf) begin
          to_inf = (rm_q == 2'b00) || (rm_q == 2'b10 && !sign_q) || (rm_q == 2'b11 && sign_q);
          res_nx = to_inf ? {sign_q, EXP_ONES, {MAN_W{1'b0}}}
                          : {sign_q, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
          flg_nx = 4'b1010;
        end else begin
          res_nx = {sign_q, e_rnd[EXP_W-1:0], frac};
          flg_nx = {1'b0, (e_rnd == '0) && inexact, inexact, (e_rnd == '0) && (frac == '0)};
        end
        state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = res_q;
  assign bus.out_flags  = flg_q;
endmodule
